seq_alu: RTL and testbench

Parametrised, registered successor to the CPU's combinational 2-bit-opcode ALU. Generalises data width, adds carry/borrow-in chaining for multi-word arithmetic, persistent carry and zero flags, a shift op, and an iterative multi-cycle multiplier behind a valid/ready input handshake. Sits between the register file and the writeback/memory-strobe logic of the CPU datapath.

---
 rtl/seq_alu_pkg.sv | 24 ++
 rtl/seq_alu_mul.sv | 47 ++++
 rtl/seq_alu.sv | 123 ++++++++++++
 tb/tb_seq_alu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcodes, MOV side-effect codes and FSM states for seq_alu.
// Pure declarations: no latency, no flow control.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBB = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [1:0] MOV_NONE = 2'b00;
  localparam logic [1:0] MOV_RD   = 2'b01;
  localparam logic [1:0] MOV_WR   = 2'b10;
  localparam logic [1:0] MOV_TGL  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier, low WIDTH bits; WIDTH cycles from start to done.
// No backpressure: start is only honoured while the owner is idle, done is a single-cycle flag.
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;

  // product is the accumulator after this cycle's step, so the final edge can write it directly
  assign product = acc + (mplier[0] ? mcand : '0);
  assign busy    = (count != '0);
  assign done    = (count == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (start) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      count  <= CNT_W'(WIDTH);
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - 1'b1;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with carry chaining, persistent C/Z flags and MOV strobes; ops 0-6 latency 1, MUL WIDTH cycles.
// in_ready drops while a MUL iterates; no output backpressure, out_valid is a one-cycle pulse.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] addrs,
  input  logic [WIDTH-1:0]  dIn0,
  input  logic [WIDTH-1:0]  dIn1,
  output logic              out_valid,
  output logic [WIDTH-1:0]  dOut,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              memRead,
  output logic              memWrite,
  output logic              toggleOut
);

  state_t           state_q, state_d;
  logic             accept;
  logic             single_op;
  logic             mul_start, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   sum, diff;
  logic [1:0]       mov_sel;
  logic             unused_addrs;

  assign in_ready     = (state_q == ST_IDLE);
  assign accept       = in_valid && in_ready;
  assign single_op    = accept && (opcode != OP_MUL);
  assign mov_sel      = addrs[ADDR_W-1 -: 2];
  assign unused_addrs = ^addrs;

  // carry_flag is already the value written by the previous accept, so ADC/SBB chain bubble-free
  assign sum  = {1'b0, dIn0} + {1'b0, dIn1} + {{WIDTH{1'b0}}, (opcode == OP_ADC) & carry_flag};
  assign diff = {1'b0, dIn0} - {1'b0, dIn1} - {{WIDTH{1'b0}}, (opcode == OP_SBB) & carry_flag};

  always_comb begin
    alu_res = '0;
    alu_c   = carry_flag;
    case (opcode)
      OP_ADD, OP_ADC: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_SUB, OP_SBB: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_XOR:         alu_res = dIn0 ^ dIn1;
      OP_MOV:         alu_res = dIn1;
      OP_SHL: begin
        alu_res = {dIn0[WIDTH-2:0], 1'b0};
        alu_c   = dIn0[WIDTH-1];
      end
      default:        alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && opcode == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done || !mul_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      dOut       <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      toggleOut  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      memRead   <= single_op && opcode == OP_MOV && mov_sel == MOV_RD;
      memWrite  <= single_op && opcode == OP_MOV && mov_sel == MOV_WR;
      toggleOut <= single_op && opcode == OP_MOV && mov_sel == MOV_TGL;
      if (single_op) begin
        out_valid  <= 1'b1;
        dOut       <= alu_res;
        carry_flag <= alu_c;
        zero_flag  <= (alu_res == '0);
      end else if (state_q == ST_MUL && mul_done) begin
        out_valid <= 1'b1;
        dOut      <= mul_product;
        zero_flag <= (mul_product == '0);
      end
    end
  end

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mul_start),
    .mcand_in  (dIn0),
    .mplier_in (dIn1),
    .busy      (mul_busy),
    .done      (mul_done),
    .product   (mul_product)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: an 8-bit and a 16-bit instance driven cycle by cycle against an arithmetic reference model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0, v1, rdy0, rdy1, ov0, ov1, cf0, cf1, zf0, zf1;
  logic        mr0, mr1, mw0, mw1, tg0, tg1;
  logic [2:0]  op0, op1;
  logic [3:0]  ad0, ad1;
  logic [7:0]  a0, b0, d0;
  logic [15:0] a1, b1, d1;

  seq_alu #(.WIDTH(8), .ADDR_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .opcode(op0), .addrs(ad0),
    .dIn0(a0), .dIn1(b0), .out_valid(ov0), .dOut(d0), .carry_flag(cf0), .zero_flag(zf0),
    .memRead(mr0), .memWrite(mw0), .toggleOut(tg0));

  seq_alu #(.WIDTH(16), .ADDR_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .opcode(op1), .addrs(ad1),
    .dIn0(a1), .dIn1(b1), .out_valid(ov1), .dOut(d1), .carry_flag(cf1), .zero_flag(zf1),
    .memRead(mr1), .memWrite(mw1), .toggleOut(tg1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // next-cycle stimulus per instance
  bit         nv[2];
  logic [2:0] nop[2];
  logic [3:0] nad[2];
  longint     na[2], nb[2];

  // reference model state per instance
  int     wd[2] = '{8, 16};
  longint e_d[2], mres[2];
  bit     e_val[2], e_c[2], e_z[2], e_rd[2], e_wr[2], e_tg[2], e_rdy[2];
  int     busy[2];

  function automatic void model(input int i);
    longint mask, a, b, t, r;
    mask = (longint'(1) << wd[i]) - 1;
    a = na[i] & mask;
    b = nb[i] & mask;
    t = 0;
    e_val[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_tg[i] = 0;
    if (busy[i] > 0) begin
      busy[i]--;
      if (busy[i] == 0) begin
        e_val[i] = 1; e_d[i] = mres[i]; e_z[i] = (mres[i] == 0);
      end
    end else if (nv[i]) begin
      case (nop[i])
        OP_ADD: t = a + b;
        OP_ADC: t = a + b + longint'(e_c[i]);
        OP_SUB: t = a - b;
        OP_SBB: t = a - b - longint'(e_c[i]);
        OP_XOR: t = a ^ b;
        OP_MOV: t = b;
        OP_SHL: t = a * 2;
        default: t = 0;
      endcase
      if (nop[i] == OP_MUL) begin
        busy[i] = wd[i];
        mres[i] = (a * b) & mask;
      end else begin
        r = t & mask;
        if (nop[i] inside {OP_ADD, OP_ADC, OP_SHL}) e_c[i] = (t > mask);
        if (nop[i] inside {OP_SUB, OP_SBB}) e_c[i] = (t < 0);
        e_val[i] = 1; e_d[i] = r; e_z[i] = (r == 0);
        if (nop[i] == OP_MOV) begin
          e_rd[i] = (nad[i][3:2] == 2'b01);
          e_wr[i] = (nad[i][3:2] == 2'b10);
          e_tg[i] = (nad[i][3:2] == 2'b11);
        end
      end
    end
    e_rdy[i] = (busy[i] == 0);
  endfunction

  task automatic check_all();
    chk("ov8",   32'(ov0),             32'(e_val[0]));
    chk("d8",    32'(d0),              32'(e_d[0]));
    chk("c8",    32'(cf0),             32'(e_c[0]));
    chk("z8",    32'(zf0),             32'(e_z[0]));
    chk("strb8", 32'({mr0, mw0, tg0}), 32'({e_rd[0], e_wr[0], e_tg[0]}));
    chk("rdy8",  32'(rdy0),            32'(e_rdy[0]));
    chk("ov16",  32'(ov1),             32'(e_val[1]));
    chk("d16",   32'(d1),              32'(e_d[1]));
    chk("c16",   32'(cf1),             32'(e_c[1]));
    chk("z16",   32'(zf1),             32'(e_z[1]));
    chk("strb16",32'({mr1, mw1, tg1}), 32'({e_rd[1], e_wr[1], e_tg[1]}));
    chk("rdy16", 32'(rdy1),            32'(e_rdy[1]));
  endtask

  // called at a falling edge: drive, predict the next rising edge, then compare at the next falling edge
  task automatic step();
    v0 = nv[0]; op0 = nop[0]; ad0 = nad[0]; a0 = 8'(na[0]);  b0 = 8'(nb[0]);
    v1 = nv[1]; op1 = nop[1]; ad1 = nad[1]; a1 = 16'(na[1]); b1 = 16'(nb[1]);
    model(0);
    model(1);
    @(negedge clk);
    check_all();
    nv[0] = 0;
    nv[1] = 0;
  endtask

  task automatic put(input int i, input logic [2:0] op, input logic [3:0] ad,
                     input longint a, input longint b);
    nv[i] = 1; nop[i] = op; nad[i] = ad; na[i] = a; nb[i] = b;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; nv[0] = 0; nv[1] = 0;
    #1;
    chk("rst_out8",  32'({ov0, cf0, zf0, mr0, mw0, tg0, d0}), 32'h0);
    chk("rst_out16", 32'({ov1, cf1, zf1, mr1, mw1, tg1, d1}), 32'h0);
    for (int i = 0; i < 2; i++) begin
      e_val[i] = 0; e_d[i] = 0; e_c[i] = 0; e_z[i] = 0;
      e_rd[i] = 0; e_wr[i] = 0; e_tg[i] = 0; busy[i] = 0; e_rdy[i] = 1;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy8",  32'(rdy0), 32'h1);
    chk("rst_rdy16", 32'(rdy1), 32'h1);
  endtask

  logic [3:0] mov_ad[4]  = '{4'h4, 4'h8, 4'hC, 4'h0};
  logic [2:0] mov_exp[4] = '{3'b100, 3'b010, 3'b001, 3'b000};

  initial begin
    int low_cnt;
    int pulses;
    v0 = 0; v1 = 0; op0 = 0; op1 = 0; ad0 = 0; ad1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    for (int i = 0; i < 2; i++) begin nv[i] = 0; nop[i] = 0; nad[i] = 0; na[i] = 0; nb[i] = 0; end
    @(negedge clk);
    do_reset();

    // carry chain
    put(0, OP_ADD, 4'h0, 'hF0, 'h20);
    chk("add_d", 32'(d0), 32'h10); chk("add_c", 32'(cf0), 32'h1); chk("add_z", 32'(zf0), 32'h0);
    put(0, OP_ADC, 4'h0, 'h00, 'h00);
    chk("adc_d", 32'(d0), 32'h01); chk("adc_c", 32'(cf0), 32'h0);

    // borrow chain
    put(0, OP_SUB, 4'h0, 'h05, 'h06);
    chk("sub_d", 32'(d0), 32'hFF); chk("sub_c", 32'(cf0), 32'h1);
    put(0, OP_SBB, 4'h0, 'h01, 'h00);
    chk("sbb_d", 32'(d0), 32'h00); chk("sbb_c", 32'(cf0), 32'h0); chk("sbb_z", 32'(zf0), 32'h1);

    // MUL with carry set beforehand and in_valid held through the busy period
    put(0, OP_ADD, 4'h0, 'hF0, 'h20);
    put(0, OP_MUL, 4'h0, 'h0D, 'h0B);
    low_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (rdy0 == 1'b0) low_cnt++;
      nv[0] = 1;
      step();
    end
    chk("mul_pulse", 32'(ov0), 32'h1);
    chk("mul_d", 32'(d0), 32'h8F);
    chk("mul_c", 32'(cf0), 32'h1);
    chk("mul_busy_cycles", 32'(low_cnt), 32'd8);
    step();
    chk("mul_once", 32'(ov0), 32'h0);

    // MOV side-effects, back to back
    for (int k = 0; k < 4; k++) begin
      put(0, OP_MOV, mov_ad[k], 'h00, 'h5A);
      chk("mov_d", 32'(d0), 32'h5A);
      chk("mov_strb", 32'({mr0, mw0, tg0}), 32'(mov_exp[k]));
    end
    step();
    chk("mov_strb_end", 32'({mr0, mw0, tg0}), 32'h0);

    // 16-bit shift and XOR
    put(1, OP_SHL, 4'h0, 'h8001, 'h0);
    chk("shl_d", 32'(d1), 32'h0002); chk("shl_c", 32'(cf1), 32'h1);
    put(1, OP_XOR, 4'h0, 'h1234, 'h1234);
    chk("xor_d", 32'(d1), 32'h0); chk("xor_z", 32'(zf1), 32'h1); chk("xor_c", 32'(cf1), 32'h1);

    // random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        nv[i]  = ($urandom_range(3) != 0);
        nop[i] = 3'($urandom_range(7));
        nad[i] = 4'($urandom_range(15));
        na[i]  = longint'($urandom);
        nb[i]  = longint'($urandom);
      end
      step();
    end
    for (int n = 0; n < 20; n++) step();

    // reset during the third MUL cycle discards the result
    put(0, OP_MUL, 4'h0, 'h0D, 'h0B);
    step();
    step();
    do_reset();
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (ov0 === 1'b1) pulses++;
    end
    chk("rst_mul_no_pulse", 32'(pulses), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
